// File: rtl/cpu_timing_pkg.sv
// cpu_timing_pkg: sequencer states and one-hot beat encodings, shared with the controller's beat decode
package cpu_timing_pkg;
    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_HALT} tstate_t;
    localparam logic [2:0] BEAT_NONE = 3'b000;
    localparam logic [2:0] BEAT_W1   = 3'b001;
    localparam logic [2:0] BEAT_W2   = 3'b010;
    localparam logic [2:0] BEAT_W3   = 3'b100;
endpackage

// File: rtl/qd_edge_det.sv
// qd_edge_det: one-cycle rise pulse from the debounced QD button level
module qd_edge_det (
    input  logic t3,
    input  logic clr,
    input  logic qd,
    output logic rise
);
    logic qd_q, armed;
    // sample qd every edge; arm only after qd was seen low, so a level held through reset is not a press
    always_ff @(posedge t3 or negedge clr)
        if (!clr) begin
            qd_q  <= 1'b0;
            armed <= 1'b0;
        end else begin
            qd_q  <= qd;
            armed <= armed | ~qd;
        end
    assign rise = qd & ~qd_q & armed;
endmodule

// File: rtl/beat_timing_gen.sv
// beat_timing_gen: one-hot W1/W2/W3 machine-beat sequencer with QD start/resume and cycle counter (option: SINGLE_STEP_EN)
module beat_timing_gen
    import cpu_timing_pkg::*;
#(
    parameter int CNT_W      = 16,
    parameter bit AUTO_START = 1'b0
) (
    input  logic             t3,
    input  logic             clr,
    input  logic             qd,
    input  logic             short,
    input  logic             long,
    input  logic             stop,
`ifdef SINGLE_STEP_EN
    input  logic             step_mode,
`endif
    output logic             w1,
    output logic             w2,
    output logic             w3,
    output logic             running,
    output logic [CNT_W-1:0] cycle_cnt
);
    tstate_t    state;
    logic [2:0] beat, saved, nxt;
    logic       rise, done, step, halt;
`ifdef SINGLE_STEP_EN
    assign step = step_mode;
`else
    assign step = 1'b0;
`endif
    qd_edge_det u_qd (.t3(t3), .clr(clr), .qd(qd), .rise(rise));
    assign {w3, w2, w1} = beat;
    // next beat from the current one (short outranks long); a cycle is done whenever the next beat is W1
    always_comb begin
        nxt  = beat == BEAT_W1 ? (short ? BEAT_W1 : BEAT_W2) :
               beat == BEAT_W2 ? (long  ? BEAT_W3 : BEAT_W1) : BEAT_W1;
        done = nxt == BEAT_W1;
        halt = stop | (step & done);
    end
    // sequencer: beat register doubles as the output and is cleared outside RUN; saved holds the resume beat
    always_ff @(posedge t3 or negedge clr)
        if (!clr) begin
            state     <= AUTO_START ? ST_RUN : ST_IDLE;
            beat      <= AUTO_START ? BEAT_W1 : BEAT_NONE;
            running   <= AUTO_START;
            saved     <= BEAT_W1;
            cycle_cnt <= '0;
        end else begin
            case (state)
                ST_RUN: begin
                    cycle_cnt <= cycle_cnt + CNT_W'(done);
                    if (halt) begin
                        state   <= ST_HALT;
                        beat    <= BEAT_NONE;
                        running <= 1'b0;
                        saved   <= nxt;
                    end else begin
                        beat <= nxt;
                    end
                end
                default: if (rise) begin
                    state   <= ST_RUN;
                    beat    <= state == ST_HALT ? saved : BEAT_W1;
                    running <= 1'b1;
                end
            endcase
        end
endmodule

// File: tb/tb_beat_timing_gen.sv
// tb_beat_timing_gen: table vectors, hand corner sequences and random run against a beat-level model
module tb_beat_timing_gen;
    logic t3 = 1'b0, clr = 1'b1, qd = 1'b0, short = 1'b0, long = 1'b0, stop = 1'b0;
`ifdef SINGLE_STEP_EN
    logic step_mode = 1'b0;
`endif
    logic w1, w2, w3, running, a1, a2, a3, arun;
    logic [15:0] cnt;
    logic [3:0]  cnt4;
    int checks = 0, failures = 0;
    int m_st, m_beat, m_saved, m_cnt;
    bit m_qdq, m_arm;

    typedef struct {
        bit sh, lg, sp, q;
        logic [2:0] w;
        int c;
    } vec_t;
    vec_t tbl[17];

    always #5 t3 = ~t3;

    beat_timing_gen dut (
        .t3(t3), .clr(clr), .qd(qd), .short(short), .long(long), .stop(stop),
`ifdef SINGLE_STEP_EN
        .step_mode(step_mode),
`endif
        .w1(w1), .w2(w2), .w3(w3), .running(running), .cycle_cnt(cnt)
    );

    beat_timing_gen #(.CNT_W(4)) dut4 (
        .t3(t3), .clr(clr), .qd(qd), .short(short), .long(long), .stop(stop),
`ifdef SINGLE_STEP_EN
        .step_mode(step_mode),
`endif
        .w1(a1), .w2(a2), .w3(a3), .running(arun), .cycle_cnt(cnt4)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        m_st = 0; m_beat = 1; m_saved = 1; m_cnt = 0; m_qdq = 0; m_arm = 0;
    endtask

    function automatic logic [2:0] model_w();
        return m_st == 1 ? 3'(1 << (m_beat - 1)) : 3'b000;
    endfunction

    task automatic model_edge();
        bit rise, done, stp;
        int nb;
        rise = qd && !m_qdq && m_arm;
        m_arm = m_arm || !qd;
        m_qdq = qd;
        stp = 0;
`ifdef SINGLE_STEP_EN
        stp = step_mode;
`endif
        if (m_st == 1) begin
            if (m_beat == 1) nb = short ? 1 : 2;
            else if (m_beat == 2) nb = long ? 3 : 1;
            else nb = 1;
            done = nb == 1;
            if (done) m_cnt++;
            if (stop || (stp && done)) begin m_st = 2; m_saved = nb; end
            else m_beat = nb;
        end else if (rise) begin
            m_beat = m_st == 2 ? m_saved : 1;
            m_st = 1;
        end
    endtask

    task automatic tick();
        @(posedge t3);
        model_edge();
        #1;
    endtask

    task automatic check_model(input string tag);
        check({tag, ".w"}, {29'd0, w3, w2, w1}, {29'd0, model_w()});
        check({tag, ".run"}, {31'd0, running}, {31'd0, m_st == 1});
        check({tag, ".cnt"}, {16'd0, cnt}, 32'(m_cnt & 16'hffff));
        check({tag, ".cnt4"}, {28'd0, cnt4}, 32'(m_cnt & 4'hf));
    endtask

    task automatic do_reset();
        @(negedge t3);
        qd = 0; short = 0; long = 0; stop = 0;
        clr = 0;
        model_reset();
        #1;
        check("reset.w", {29'd0, w3, w2, w1}, 32'd0);
        check("reset.run", {31'd0, running}, 32'd0);
        check("reset.cnt", {16'd0, cnt}, 32'd0);
        @(negedge t3);
        clr = 1;
    endtask

    // beats must be one-hot or zero at all times, and zero whenever not running
    always @(negedge t3) if (clr) begin
        checks++;
        if ($countones({w3, w2, w1}) > 1 || (!running && {w3, w2, w1} != 3'b000)) begin
            failures++;
            $display("FAIL onehot at %0t: w=%b running=%b", $time, {w3, w2, w1}, running);
        end
    end

    initial begin
        tbl = '{
            '{0,0,0,0, 3'b000, 0}, '{0,0,0,1, 3'b001, 0}, '{0,0,0,1, 3'b010, 0},
            '{0,0,0,0, 3'b001, 1}, '{1,0,0,0, 3'b001, 2}, '{1,1,0,0, 3'b001, 3},
            '{0,0,0,0, 3'b010, 3}, '{0,1,0,0, 3'b100, 3}, '{1,1,0,0, 3'b001, 4},
            '{0,0,1,0, 3'b000, 4}, '{0,0,0,1, 3'b010, 4}, '{0,0,1,1, 3'b000, 5},
            '{0,0,0,0, 3'b000, 5}, '{0,0,0,1, 3'b001, 5}, '{1,0,0,1, 3'b001, 6},
            '{0,1,0,0, 3'b010, 6}, '{0,1,0,0, 3'b100, 6}
        };
        #1;
        do_reset();
        for (int i = 0; i < 17; i++) begin
            short = tbl[i].sh; long = tbl[i].lg; stop = tbl[i].sp; qd = tbl[i].q;
            tick();
            check($sformatf("vec%0d.w", i), {29'd0, w3, w2, w1}, {29'd0, tbl[i].w});
            check($sformatf("vec%0d.cnt", i), {16'd0, cnt}, 32'(tbl[i].c));
            check_model($sformatf("vec%0d.model", i));
        end

        do_reset();
        qd = 0; tick();
        qd = 1; tick();
        qd = 0; short = 1; tick();
        short = 0; tick();
        long = 1; tick();
        check("pre_clr.w", {29'd0, w3, w2, w1}, 32'b100);
        check("pre_clr.cnt", {16'd0, cnt}, 32'd1);
        #2 clr = 0;
        #1;
        check("async_clr.w", {29'd0, w3, w2, w1}, 32'd0);
        check("async_clr.cnt", {16'd0, cnt}, 32'd0);
        check("async_clr.run", {31'd0, running}, 32'd0);
        model_reset();
        long = 0; qd = 1;
        @(negedge t3); clr = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("qd_held.w", {29'd0, w3, w2, w1}, 32'd0);
        end
        qd = 0; tick();
        qd = 1; tick();
        check("qd_repress.w", {29'd0, w3, w2, w1}, 32'b001);
        check_model("qd_repress");

        do_reset();
        qd = 0; tick();
        qd = 1; tick();
        short = 1;
        repeat (17) tick();
        check("wrap.cnt", {16'd0, cnt}, 32'd17);
        check("wrap.cnt4", {28'd0, cnt4}, 32'd1);
        check("wrap.w", {29'd0, w3, w2, w1}, 32'b001);

`ifdef SINGLE_STEP_EN
        do_reset();
        step_mode = 1; long = 1;
        tick();
        for (int p = 0; p < 3; p++) begin
            qd = 1; tick();
            check("step.w1", {29'd0, w3, w2, w1}, 32'b001);
            qd = 0; tick();
            check("step.w2", {29'd0, w3, w2, w1}, 32'b010);
            tick();
            check("step.w3", {29'd0, w3, w2, w1}, 32'b100);
            stop = p == 2; tick(); stop = 0;
            check("step.halt", {29'd0, w3, w2, w1, running}, 32'd0);
            check("step.cnt", {16'd0, cnt}, 32'(p + 1));
        end
        step_mode = 0; long = 0;
`endif

        do_reset();
        for (int i = 0; i < 600; i++) begin
            short = $urandom_range(0, 9) < 3;
            long  = $urandom_range(0, 9) < 4;
            stop  = $urandom_range(0, 9) == 0;
            if ($urandom_range(0, 3) == 0) qd = ~qd;
            tick();
            check_model($sformatf("rand%0d", i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
